// File: rtl/ecc_scrub_scheduler_if.sv
// Scrub request/grant handshake between the scheduler and the per-bank scrubbers.
// The scheduler uses the master view, the scrubbers use the slave view.
interface ecc_scrub_scheduler_if #(
    parameter int unsigned NumBanks = 6
);
    logic [NumBanks-1:0] scrub_req;
    logic [NumBanks-1:0] scrub_gnt;

    modport master (output scrub_req, input scrub_gnt);
    modport slave  (input scrub_req, output scrub_gnt);
endinterface

// File: rtl/ecc_scrub_scheduler.sv
// Per-bank ECC fault bookkeeping and round-robin scrub scheduling.
// Saturating event counters, sticky threshold/uncorrectable interrupts,
// interval-driven scrub requests with overrun detection and per-bank
// active-low test write masks.
module ecc_scrub_scheduler #(
    parameter int unsigned NumBanks      = 6,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned EccWidth      = 7,
    parameter int unsigned CntWidth      = 16,
    parameter int unsigned IntervalWidth = 32,
    localparam int unsigned MaskWidth    = DataWidth + EccWidth,
    localparam int unsigned BankIdxWidth = (NumBanks > 1) ? $clog2(NumBanks) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [IntervalWidth-1:0]             cfg_scrub_interval_i,
    input  logic [NumBanks-1:0]                  cfg_bank_en_i,
    input  logic [CntWidth-1:0]                  cfg_threshold_i,
    input  logic [NumBanks-1:0]                  cnt_clear_i,
    input  logic [NumBanks-1:0]                  irq_clear_i,
    input  logic                                 cfg_mask_we_i,
    input  logic [BankIdxWidth-1:0]              cfg_mask_bank_i,
    input  logic [MaskWidth-1:0]                 cfg_mask_i,
    input  logic [NumBanks-1:0]                  bank_fault_i,
    input  logic [NumBanks-1:0]                  scrub_fix_i,
    input  logic [NumBanks-1:0]                  uncorrectable_i,
    ecc_scrub_scheduler_if.master                scrub,
    output logic [NumBanks-1:0][CntWidth-1:0]    mismatch_count_o,
    output logic [NumBanks-1:0][CntWidth-1:0]    scrub_fix_count_o,
    output logic [NumBanks-1:0][CntWidth-1:0]    uncorrectable_count_o,
    output logic [NumBanks-1:0]                  irq_status_o,
    output logic [NumBanks-1:0]                  scrub_overrun_o,
    output logic                                 irq_o,
    output logic [NumBanks-1:0][MaskWidth-1:0]   test_write_mask_no
);

    localparam logic [IntervalWidth-1:0] IntOne  = IntervalWidth'(1);
    localparam logic [CntWidth-1:0]      CntOne  = CntWidth'(1);
    localparam logic [BankIdxWidth-1:0]  BankOne = BankIdxWidth'(1);

    logic [IntervalWidth-1:0] tick_cnt;
    logic                     tick;
    logic [BankIdxWidth-1:0]  ptr;
    logic [BankIdxWidth-1:0]  target;
    logic                     target_valid;
    logic [NumBanks-1:0]      tick_hit;

    // Tick fires once the count reaches interval-1 (or overshoots after the interval was lowered).
    always_comb begin
        tick = (cfg_scrub_interval_i != '0) && (tick_cnt >= cfg_scrub_interval_i - IntOne);
    end

    // Interval counter: held at 0 while scheduling is disabled, restarts on every tick.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tick_cnt <= '0;
        end else if ((cfg_scrub_interval_i == '0) || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + IntOne;
        end
    end

    // First enabled bank at or after the pointer, wrapping around.
    always_comb begin
        target_valid = 1'b0;
        target       = '0;
        for (int unsigned k = 0; k < NumBanks; k++) begin
            if (!target_valid &&
                cfg_bank_en_i[BankIdxWidth'((32'(ptr) + k) % NumBanks)]) begin
                target_valid = 1'b1;
                target       = BankIdxWidth'((32'(ptr) + k) % NumBanks);
            end
        end
        tick_hit = '0;
        if (tick && target_valid) begin
            tick_hit[target] = 1'b1;
        end
    end

    // Rotation pointer advances past the served bank; a dropped tick leaves it alone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (tick && target_valid) begin
            ptr <= (32'(target) == NumBanks - 1) ? '0 : target + BankOne;
        end
    end

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        logic [CntWidth-1:0]  mis_q;
        logic [CntWidth-1:0]  fix_q;
        logic [CntWidth-1:0]  unc_q;
        logic                 irq_q;
        logic                 ovr_q;
        logic                 req_q;
        logic [MaskWidth-1:0] mask_q;
        logic                 inc_mis;
        logic                 inc_fix;
        logic                 inc_unc;
        logic                 irq_set;

        // Increments only below saturation; threshold hits only on a real (uncleared) increment.
        always_comb begin
            inc_mis = bank_fault_i[b] && (mis_q != '1);
            inc_fix = scrub_fix_i[b] && (fix_q != '1);
            inc_unc = uncorrectable_i[b] && (unc_q != '1);
            irq_set = uncorrectable_i[b] ||
                      ((cfg_threshold_i != '0) && !cnt_clear_i[b] &&
                       ((inc_mis && (mis_q + CntOne == cfg_threshold_i)) ||
                        (inc_fix && (fix_q + CntOne == cfg_threshold_i)) ||
                        (inc_unc && (unc_q + CntOne == cfg_threshold_i))));
        end

        // Saturating event counters; clear beats a same-cycle increment.
        always_ff @(posedge clk_i) begin
            if (rst_i || cnt_clear_i[b]) begin
                mis_q <= '0;
                fix_q <= '0;
                unc_q <= '0;
            end else begin
                if (inc_mis) mis_q <= mis_q + CntOne;
                if (inc_fix) fix_q <= fix_q + CntOne;
                if (inc_unc) unc_q <= unc_q + CntOne;
            end
        end

        // Sticky irq/overrun flags where a same-cycle set wins over clear; request held until granted.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                irq_q <= 1'b0;
                ovr_q <= 1'b0;
                req_q <= 1'b0;
            end else begin
                irq_q <= irq_set || (irq_q && !irq_clear_i[b]);
                ovr_q <= (tick_hit[b] && req_q && !scrub.scrub_gnt[b]) ||
                         (ovr_q && !irq_clear_i[b]);
                req_q <= (req_q && !scrub.scrub_gnt[b]) || tick_hit[b];
            end
        end

        // Test write mask; out-of-range bank indices never match any bank.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                mask_q <= '1;
            end else if (cfg_mask_we_i && (cfg_mask_bank_i == BankIdxWidth'(b))) begin
                mask_q <= cfg_mask_i;
            end
        end

        assign mismatch_count_o[b]      = mis_q;
        assign scrub_fix_count_o[b]     = fix_q;
        assign uncorrectable_count_o[b] = unc_q;
        assign irq_status_o[b]          = irq_q;
        assign scrub_overrun_o[b]       = ovr_q;
        assign scrub.scrub_req[b]       = req_q;
        assign test_write_mask_no[b]    = mask_q;
    end

    // Interrupt line is the OR of all status bits.
    always_comb begin
        irq_o = |irq_status_o;
    end

endmodule

// File: tb/tb_ecc_scrub_scheduler.sv
// Self-checking bench for ecc_scrub_scheduler (NumBanks=6, CntWidth=4).
module tb_ecc_scrub_scheduler;
    localparam int NB = 6;
    localparam int DW = 32;
    localparam int EW = 7;
    localparam int CW = 4;
    localparam int IW = 32;
    localparam int MW = DW + EW;
    localparam int BW = 3;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [IW-1:0]          interval;
    logic [NB-1:0]          bank_en;
    logic [CW-1:0]          threshold;
    logic [NB-1:0]          cnt_clear;
    logic [NB-1:0]          irq_clear;
    logic                   mask_we;
    logic [BW-1:0]          mask_bank;
    logic [MW-1:0]          mask_val;
    logic [NB-1:0]          bank_fault;
    logic [NB-1:0]          scrub_fix;
    logic [NB-1:0]          uncorrectable;
    logic [NB-1:0][CW-1:0]  mismatch_count;
    logic [NB-1:0][CW-1:0]  scrub_fix_count;
    logic [NB-1:0][CW-1:0]  uncorrectable_count;
    logic [NB-1:0]          irq_status;
    logic [NB-1:0]          scrub_overrun;
    logic                   irq;
    logic [NB-1:0][MW-1:0]  test_write_mask;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    ecc_scrub_scheduler_if #(.NumBanks(NB)) scrub_bus ();

    ecc_scrub_scheduler #(
        .NumBanks(NB), .DataWidth(DW), .EccWidth(EW), .CntWidth(CW), .IntervalWidth(IW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .cfg_scrub_interval_i(interval),
        .cfg_bank_en_i(bank_en),
        .cfg_threshold_i(threshold),
        .cnt_clear_i(cnt_clear),
        .irq_clear_i(irq_clear),
        .cfg_mask_we_i(mask_we),
        .cfg_mask_bank_i(mask_bank),
        .cfg_mask_i(mask_val),
        .bank_fault_i(bank_fault),
        .scrub_fix_i(scrub_fix),
        .uncorrectable_i(uncorrectable),
        .scrub(scrub_bus),
        .mismatch_count_o(mismatch_count),
        .scrub_fix_count_o(scrub_fix_count),
        .uncorrectable_count_o(uncorrectable_count),
        .irq_status_o(irq_status),
        .scrub_overrun_o(scrub_overrun),
        .irq_o(irq),
        .test_write_mask_no(test_write_mask)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        interval = '0; bank_en = '0; threshold = '0; cnt_clear = '0; irq_clear = '0;
        mask_we = 1'b0; mask_bank = '0; mask_val = '0; bank_fault = '0; scrub_fix = '0;
        uncorrectable = '0; scrub_bus.scrub_gnt = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [NB-1:0][MW-1:0] ones;
        ones = '1;
        // Busy inputs during reset must be ignored.
        clear_inputs();
        interval = 1; bank_en = '1; bank_fault = '1; scrub_fix = '1; uncorrectable = '1;
        mask_we = 1'b1; mask_bank = 0; mask_val = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        clear_inputs();
        checks++;
        if (mismatch_count !== '0 || scrub_fix_count !== '0 || uncorrectable_count !== '0) begin
            errors++; $display("FAIL reset_counters: got %0h/%0h/%0h expected 0",
                               mismatch_count, scrub_fix_count, uncorrectable_count);
        end
        checks++;
        if (scrub_bus.scrub_req !== '0 || irq_status !== '0 || scrub_overrun !== '0 || irq !== 1'b0) begin
            errors++; $display("FAIL reset_flags: req %0h irq_status %0h overrun %0h irq %0b expected all 0",
                               scrub_bus.scrub_req, irq_status, scrub_overrun, irq);
        end
        checks++;
        if (test_write_mask !== ones) begin
            errors++; $display("FAIL reset_masks: got %0h expected all-ones", test_write_mask);
        end
    endtask

    task automatic test_rotation();
        logic [NB-1:0] prev, rise;
        int last, exp_b;
        do_reset();
        interval = 4; bank_en = 6'b000101;
        exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(2);
        last = -1; prev = '0;
        for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
            step();
            rise = scrub_bus.scrub_req & ~prev;
            prev = scrub_bus.scrub_req;
            scrub_bus.scrub_gnt = '0;
            if (rise != '0) begin
                exp_b = exp_q.pop_front();
                checks++;
                if (rise !== (NB'(1) << exp_b)) begin
                    errors++; $display("FAIL rotation_bank: got req %0h expected %0h", rise, NB'(1) << exp_b);
                end
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 4) begin
                        errors++; $display("FAIL rotation_spacing: got %0d cycles expected 4", cyc - last);
                    end
                end
                last = cyc;
                scrub_bus.scrub_gnt = scrub_bus.scrub_req;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL rotation_timeout: got %0d requests pending expected 0", exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (scrub_overrun !== '0) begin
            errors++; $display("FAIL rotation_overrun: got %0h expected 0", scrub_overrun);
        end
        clear_inputs();
        step();
    endtask

    task automatic test_overrun();
        bit seen;
        do_reset();
        interval = 3; bank_en = 6'b000010;
        seen = 1'b0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            step();
            seen = scrub_bus.scrub_req[1];
        end
        checks++;
        if (!seen || scrub_overrun !== '0) begin
            errors++; $display("FAIL overrun_first_tick: req seen %0b overrun %0h expected 1/0", seen, scrub_overrun);
        end
        repeat (3) step();
        checks++;
        if (scrub_overrun !== 6'b000010 || scrub_bus.scrub_req !== 6'b000010) begin
            errors++; $display("FAIL overrun_second_tick: overrun %0h req %0h expected 2/2",
                               scrub_overrun, scrub_bus.scrub_req);
        end
        scrub_bus.scrub_gnt = 6'b000010;
        interval = 0;
        step();
        scrub_bus.scrub_gnt = '0;
        checks++;
        if (scrub_bus.scrub_req !== '0 || scrub_overrun !== 6'b000010) begin
            errors++; $display("FAIL overrun_grant: req %0h overrun %0h expected 0/2",
                               scrub_bus.scrub_req, scrub_overrun);
        end
        irq_clear = 6'b000010;
        step();
        irq_clear = '0;
        checks++;
        if (scrub_overrun !== '0) begin
            errors++; $display("FAIL overrun_clear: got %0h expected 0", scrub_overrun);
        end
    endtask

    task automatic test_saturation();
        logic [CW-1:0] exp_cnt;
        do_reset();
        exp_cnt = '0;
        bank_fault[3] = 1'b1;
        for (int p = 0; p < 20; p++) begin
            step();
            exp_cnt = (exp_cnt == 4'hF) ? 4'hF : exp_cnt + 4'h1;
            checks++;
            if (mismatch_count[3] !== exp_cnt) begin
                errors++; $display("FAIL saturate_pulse%0d: got %0d expected %0d", p, mismatch_count[3], exp_cnt);
            end
        end
        cnt_clear[3] = 1'b1;
        step();
        cnt_clear = '0;
        bank_fault = '0;
        checks++;
        if (mismatch_count !== '0) begin
            errors++; $display("FAIL saturate_clear: got %0h expected 0", mismatch_count);
        end
    endtask

    task automatic test_irq();
        do_reset();
        threshold = 5;
        for (int p = 1; p <= 5; p++) begin
            scrub_fix[0] = 1'b1;
            step();
            scrub_fix = '0;
            checks++;
            if (scrub_fix_count[0] !== CW'(p) || irq_status[0] !== (p >= 5) || irq !== (p >= 5)) begin
                errors++; $display("FAIL irq_pulse%0d: count %0d status %0b irq %0b expected %0d/%0b",
                                   p, scrub_fix_count[0], irq_status[0], irq, p, p >= 5);
            end
        end
        step();
        checks++;
        if (irq_status !== 6'b000001) begin
            errors++; $display("FAIL irq_sticky: got %0h expected 1", irq_status);
        end
        irq_clear[0] = 1'b1;
        step();
        irq_clear = '0;
        checks++;
        if (irq_status !== '0 || irq !== 1'b0) begin
            errors++; $display("FAIL irq_clear: status %0h irq %0b expected 0/0", irq_status, irq);
        end
        irq_clear[0] = 1'b1;
        uncorrectable[0] = 1'b1;
        step();
        irq_clear = '0;
        uncorrectable = '0;
        checks++;
        if (irq_status !== 6'b000001 || irq !== 1'b1 || uncorrectable_count[0] !== 4'd1) begin
            errors++; $display("FAIL irq_set_wins: status %0h irq %0b ucount %0d expected 1/1/1",
                               irq_status, irq, uncorrectable_count[0]);
        end
    endtask

    task automatic test_mask();
        logic [NB-1:0][MW-1:0] exp_m;
        do_reset();
        exp_m = '1;
        mask_we = 1'b1; mask_bank = 4; mask_val = 39'h7F_FFFF_FFFE;
        step();
        exp_m[4] = 39'h7F_FFFF_FFFE;
        checks++;
        if (test_write_mask !== exp_m) begin
            errors++; $display("FAIL mask_write: got %0h expected %0h", test_write_mask, exp_m);
        end
        mask_bank = 7; mask_val = '0;
        step();
        mask_we = 1'b0;
        checks++;
        if (test_write_mask !== exp_m) begin
            errors++; $display("FAIL mask_out_of_range: got %0h expected %0h", test_write_mask, exp_m);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_m = '1;
        checks++;
        if (test_write_mask !== exp_m) begin
            errors++; $display("FAIL mask_reset: got %0h expected all-ones", test_write_mask);
        end
    endtask

    task automatic test_interval_change();
        logic [NB-1:0] prev, rise;
        bit any_req;
        do_reset();
        bank_en = 6'b000001;
        interval = 100;
        any_req = 1'b0;
        repeat (50) begin
            step();
            if (scrub_bus.scrub_req != '0) any_req = 1'b1;
        end
        checks++;
        if (any_req) begin
            errors++; $display("FAIL interval_early_req: got request expected none");
        end
        interval = 2;
        exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(5); exp_q.push_back(7);
        prev = '0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            step();
            rise = scrub_bus.scrub_req & ~prev;
            prev = scrub_bus.scrub_req;
            scrub_bus.scrub_gnt = '0;
            if (rise != '0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL interval_extra_req: got req at cycle %0d expected none", cyc);
                end else if (exp_q[0] != cyc || rise !== 6'b000001) begin
                    errors++; $display("FAIL interval_req_time: got cycle %0d req %0h expected cycle %0d req 1",
                                       cyc, rise, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
                scrub_bus.scrub_gnt = scrub_bus.scrub_req;
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL interval_missing_req: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        interval = 0;
        scrub_bus.scrub_gnt = '1;
        step();
        scrub_bus.scrub_gnt = '0;
        any_req = 1'b0;
        repeat (10) begin
            step();
            if (scrub_bus.scrub_req != '0) any_req = 1'b1;
        end
        checks++;
        if (any_req) begin
            errors++; $display("FAIL interval_zero: got request expected none");
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_rotation();
        test_overrun();
        test_saturation();
        test_irq();
        test_mask();
        test_interval_change();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ecc_scrub_scheduler.md
# ecc_scrub_scheduler

Per-bank ECC fault bookkeeping and scrub scheduling for multi-bank ECC SRAMs, the parametrised successor to the single-interval ECC manager. It counts corrected-on-access, corrected-on-scrub and uncorrectable events per bank in saturating counters. Banks whose counts cross a threshold raise a sticky interrupt. Scrub requests go out one bank per interval tick, round-robin over enabled banks, with a req/gnt handshake and overrun detection. It also holds per-bank test write masks. It sits between the banks' ECC wrappers/scrubbers and a register front-end, which drives the `cfg_*` inputs and reads the outputs.

## Interface
Parameters:
- `NumBanks`, 6, number of SRAM banks (>=1)
- `DataWidth`, 32, data bits per word
- `EccWidth`, 7, ECC bits per word
- `CntWidth`, 16, width of each fault counter
- `IntervalWidth`, 32, width of scrub interval and tick counter

Ports:
- `clk_i` in 1: clock; the block has one clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `cfg_scrub_interval_i` in IntervalWidth: cycles between scrub ticks; 0 disables scheduling.
- `cfg_bank_en_i` in NumBanks: bank participates in the scrub rotation.
- `cfg_threshold_i` in CntWidth: interrupt threshold; 0 disables threshold interrupts.
- `cnt_clear_i` in NumBanks: clear all three counters of a bank.
- `irq_clear_i` in NumBanks: clear a bank's irq status and overrun bit.
- `cfg_mask_we_i` in 1: write-enable for a test mask.
- `cfg_mask_bank_i` in $clog2(NumBanks) (min 1): target bank of the mask write.
- `cfg_mask_i` in DataWidth+EccWidth: mask value; active-low, 0 = bit masked.
- `bank_fault_i` in NumBanks: 1-cycle pulse per corrected error on access.
- `scrub_fix_i` in NumBanks: 1-cycle pulse per correction by the scrubber.
- `uncorrectable_i` in NumBanks: 1-cycle pulse per uncorrectable error.
- `scrub_gnt_i` in NumBanks: scrubber accepts the request.
- `scrub_req_o` out NumBanks: scrub request per bank.
- `mismatch_count_o` out NumBanks×CntWidth: access-correction counts.
- `scrub_fix_count_o` out NumBanks×CntWidth: scrub-correction counts.
- `uncorrectable_count_o` out NumBanks×CntWidth: uncorrectable counts.
- `irq_status_o` out NumBanks: sticky per-bank interrupt status.
- `scrub_overrun_o` out NumBanks: sticky flag; a tick hit a bank whose request was still pending.
- `irq_o` out 1: OR of `irq_status_o`.
- `test_write_mask_no` out NumBanks×(DataWidth+EccWidth): per-bank write masks; [DataWidth-1:0] data, upper bits ECC.

## Operation
- Reset values: all counters 0, `scrub_req_o` 0, `irq_status_o` 0, `scrub_overrun_o` 0, `irq_o` 0, `test_write_mask_no` all-ones, tick counter 0, rotation pointer 0.
- **Counters**
  - Each event pulse increments the matching counter by 1.
  - Counters saturate at 2^CntWidth-1 and never wrap.
  - `cnt_clear_i[i]` zeroes all three counters of bank i. Clear wins over a same-cycle increment.
- **Interrupt status**
  - `irq_status_o[i]` sets when an increment of any bank-i counter produces a value equal to `cfg_threshold_i`, with the threshold nonzero.
  - It also sets on any `uncorrectable_i[i]` pulse, regardless of threshold.
  - `irq_clear_i[i]` clears it. A same-cycle set wins over clear, so events are never lost.
- **Tick counter**
  - Counts up each cycle while the interval is nonzero.
  - When its count >= interval-1, it issues a tick and returns to 0.
  - Lowering the interval below the current count therefore ticks on the next cycle.
  - An interval of 0 holds the counter at 0, with no ticks.
- **Rotation**
  - On a tick, the target is the first enabled bank at or after the pointer, searching with wrap-around.
  - The target's request bit is set, and the pointer moves to target+1 (mod NumBanks).
  - With no bank enabled, the tick is dropped and the pointer is unchanged.
- **Handshake**
  - `scrub_req_o[i]` stays high until a cycle with `scrub_gnt_i[i]`=1 and clears in the following cycle. A grant without a request is ignored.
  - Disabling a bank does not withdraw an outstanding request.
  - A tick targeting bank i while `scrub_req_o[i]` is high sets `scrub_overrun_o[i]`. The request stays high and is not duplicated.
  - The same cycle's grant is considered first: if gnt and tick hit the same bank, the request stays set and no overrun is flagged.
- **Test masks**: `cfg_mask_we_i` writes `cfg_mask_i` into bank `cfg_mask_bank_i`. Indices >= NumBanks are ignored.

## Timing
- All outputs are registered except `irq_o`, which is a combinational OR of the status registers.
- Latencies:
  - Event pulse in cycle t → counter updated and visible at t+1; irq status and `irq_o` also at t+1.
  - Tick decision in cycle t → `scrub_req_o` high at t+1.
  - Grant sampled at t → request low at t+1.
  - Mask write at t → visible at t+1.
- Reset asserted mid-operation returns every state element to its reset value at the next edge. Inputs in that cycle are ignored.

## Test plan
- Interval=4, banks 0,2 enabled, grant one cycle after each req → requests to bank 0, 2, 0, 2 at 4-cycle spacing, no overrun.
- Interval=3, bank 1 enabled, gnt held low → req[1] high from the first tick; scrub_overrun_o[1]=1 after the second tick; a later gnt drops req[1] the next cycle.
- CntWidth=4, 20 pulses on bank_fault_i[3] → mismatch_count_o[3]=15 and holds; cnt_clear_i coincident with a pulse → 0.
- Threshold=5, 5 scrub_fix_i[0] pulses → irq_status_o[0] and irq_o rise the cycle after the 5th; irq_clear_i alone → both low next cycle; irq_clear_i coincident with an uncorrectable_i[0] pulse → status stays 1.
- Mask write 0x7F_FFFF_FFFE to bank 4 → test_write_mask_no[4] shows it next cycle; write to bank index 7 (NumBanks=6) → no change; rst_i → all-ones.
- Interval changed from 100 to 2 while the counter is at 50 → tick next cycle, then every 2 cycles; interval 0 → no further requests.
